// File: rtl/mips_test_sequencer.sv
// Self-checking load/run/dump sequencer for pipe_MIPS32.
// Define MIPS_SEQ_REGINIT_EN to preload R[k]=k (k=0..30) before the core starts.
module mips_test_sequencer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NREG    = 6,
   parameter int TIMEOUT = 255
) (
   input  logic                        clk1,
   input  logic                        rst_n,
   input  logic                        go,
   input  logic                        prog_valid,
   output logic                        prog_ready,
   input  logic [DATA_W-1:0]           prog_data,
   input  logic                        prog_last,
   output logic                        imem_we,
   output logic [ADDR_W-1:0]           imem_addr,
   output logic [DATA_W-1:0]           imem_wdata,
   output logic                        reg_we,
   output logic [4:0]                  reg_waddr,
   output logic [DATA_W-1:0]           reg_wdata,
   output logic                        core_start,
   input  logic                        core_halted,
   output logic [4:0]                  reg_raddr,
   input  logic [DATA_W-1:0]           reg_rdata,
   input  logic [DATA_W-1:0]           exp_data,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout,
   output logic [$clog2(NREG+1)-1:0]   err_count
);

   localparam int EW = $clog2(NREG + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = (TW > 6) ? TW : 6;

   localparam logic [CW-1:0] C_TMO  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_NREG = CW'(NREG);
   localparam logic [EW-1:0] C_ESAT = EW'(NREG);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef MIPS_SEQ_REGINIT_EN
      S_INIT  = 3'd2,
`endif
      S_START = 3'd3,
      S_RUN   = 3'd4,
      S_DUMP  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

`ifdef MIPS_SEQ_REGINIT_EN
   localparam state_t S_POST_LOAD = S_INIT;
   localparam logic [CW-1:0] C_INIT_LAST = CW'(30);
`else
   localparam state_t S_POST_LOAD = S_START;
`endif

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [CW-1:0]       r_cnt;
   logic [DATA_W-1:0]   r_exp;
   logic [EW-1:0]       r_err;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic                r_tmo;

   logic w_load;
   logic w_hs;
   logic w_dump;
   logic w_cmp;
   logic w_mis;
   logic w_err_inc;

   assign w_load = (r_state == S_LOAD);
   assign w_hs   = w_load & prog_valid;
   assign w_dump = (r_state == S_DUMP);

   assign prog_ready = w_load;
   assign imem_we    = w_hs;
   assign imem_addr  = w_load ? r_wr_ptr : '0;
   assign imem_wdata = w_hs ? prog_data : '0;

`ifdef MIPS_SEQ_REGINIT_EN
   logic w_init;
   assign w_init    = (r_state == S_INIT);
   assign reg_we    = w_init;
   assign reg_waddr = w_init ? r_cnt[4:0] : '0;
   assign reg_wdata = w_init ? DATA_W'(r_cnt[4:0]) : '0;
`else
   assign reg_we    = 1'b0;
   assign reg_waddr = '0;
   assign reg_wdata = '0;
`endif

   assign core_start = (r_state == S_START);
   assign reg_raddr  = (w_dump && r_cnt < C_NREG) ? r_cnt[4:0] : '0;

   // Read data lags the address by one cycle, so compare against last cycle's expectation.
   assign w_cmp     = w_dump && (r_cnt != '0);
   assign w_mis     = w_cmp && (reg_rdata != r_exp);
   assign w_err_inc = w_mis && (r_err != C_ESAT);

   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign timeout   = r_tmo;
   assign err_count = r_err;

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
         r_exp    <= '0;
         r_err    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_tmo    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  r_state  <= S_LOAD;
                  r_wr_ptr <= '0;
                  r_cnt    <= '0;
                  r_err    <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_pass   <= 1'b0;
                  r_tmo    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (prog_valid) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (prog_last || r_wr_ptr == '1) begin
                     r_state <= S_POST_LOAD;
                     r_cnt   <= '0;
                  end
               end
            end
`ifdef MIPS_SEQ_REGINIT_EN
            S_INIT: begin
               if (r_cnt == C_INIT_LAST) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_START: begin
               r_state <= S_RUN;
               r_cnt   <= '0;
            end
            S_RUN: begin
               // First RUN cycle may still see HALTED from the previous program.
               if (r_cnt != '0 && core_halted) begin
                  r_state <= S_DUMP;
                  r_cnt   <= '0;
               end else if (r_cnt == C_TMO) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b0;
                  r_tmo   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DUMP: begin
               r_exp <= exp_data;
               if (w_err_inc)
                  r_err <= r_err + 1'b1;
               if (r_cnt == C_NREG) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err == '0) && !w_mis && !r_tmo;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer with a tiny behavioural MIPS core model.
// Scoreboards hold expected imem writes and expected final status.
module tb_mips_test_sequencer;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NR  = 6;
   localparam int TMO = 40;
   localparam int EW  = $clog2(NR + 1);
`ifdef MIPS_SEQ_REGINIT_EN
   localparam int N_RWE = 31;
`else
   localparam int N_RWE = 0;
`endif

   logic           clk1;
   logic           rst_n;
   logic           go;
   logic           prog_valid;
   logic           prog_ready;
   logic [DW-1:0]  prog_data;
   logic           prog_last;
   logic           imem_we;
   logic [AW-1:0]  imem_addr;
   logic [DW-1:0]  imem_wdata;
   logic           reg_we;
   logic [4:0]     reg_waddr;
   logic [DW-1:0]  reg_wdata;
   logic           core_start;
   logic           core_halted;
   logic [4:0]     reg_raddr;
   logic [DW-1:0]  reg_rdata;
   logic [DW-1:0]  exp_data;
   logic           busy;
   logic           done;
   logic           pass;
   logic           timeout;
   logic [EW-1:0]  err_count;

   mips_test_sequencer #(
      .DATA_W(DW), .ADDR_W(AW), .NREG(NR), .TIMEOUT(TMO)
   ) dut (
      .clk1(clk1), .rst_n(rst_n), .go(go),
      .prog_valid(prog_valid), .prog_ready(prog_ready),
      .prog_data(prog_data), .prog_last(prog_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .core_start(core_start), .core_halted(core_halted),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .exp_data(exp_data),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_count(err_count)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   // ---------------- core model ----------------
   logic [31:0] m_imem [32];
   logic [31:0] m_regs [32];
   logic [4:0]  m_pc;
   logic        m_run;
   logic        m_halted;
   int          m_hcnt;
   logic [1:0]  st_ph;
   logic        clr;
   logic        stale_en;
   logic [31:0] exp_tbl [NR];

   logic [31:0] w_ins;
   logic [5:0]  w_op;
   logic [4:0]  w_rs, w_rt, w_rd;
   assign w_ins = m_imem[m_pc];
   assign w_op  = w_ins[31:26];
   assign w_rs  = w_ins[25:21];
   assign w_rt  = w_ins[20:16];
   assign w_rd  = w_ins[15:11];

   // Stale HALTED persists through START and the first RUN cycle.
   assign core_halted = m_halted | (stale_en & (st_ph != 2'd2));
   assign exp_data = (int'(reg_raddr) < NR) ? exp_tbl[reg_raddr] : 32'h0;

   always @(posedge clk1) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'h0;
            m_imem[i] <= 32'h0;
         end
         m_pc     <= 5'd0;
         m_run    <= 1'b0;
         m_halted <= 1'b0;
         m_hcnt   <= 0;
         st_ph    <= 2'd0;
      end else begin
         if (imem_we) m_imem[imem_addr] <= imem_wdata;
         if (reg_we) m_regs[reg_waddr] <= reg_wdata;
         if (core_start) begin
            m_pc     <= 5'd0;
            m_halted <= 1'b0;
            m_run    <= 1'b1;
            m_hcnt   <= 0;
            st_ph    <= 2'd1;
         end else begin
            if (st_ph == 2'd1) st_ph <= 2'd2;
            if (m_run) begin
               if (m_hcnt > 0) begin
                  m_hcnt <= m_hcnt - 1;
                  if (m_hcnt == 1) begin
                     m_halted <= 1'b1;
                     m_run    <= 1'b0;
                  end
               end else begin
                  case (w_op)
                     6'h00: if (w_rd != 0) m_regs[w_rd] <= m_regs[w_rs] + m_regs[w_rt];
                     6'h03: if (w_rd != 0) m_regs[w_rd] <= m_regs[w_rs] | m_regs[w_rt];
                     6'h0a: if (w_rt != 0) m_regs[w_rt] <= m_regs[w_rs] + {{16{w_ins[15]}}, w_ins[15:0]};
                     6'h3f: m_hcnt <= 3;
                     default: ;
                  endcase
                  m_pc <= m_pc + 5'd1;
               end
            end
         end
      end
      reg_rdata <= m_regs[reg_raddr];
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_mis = 0;
   int n_wr = 0, n_cs = 0, n_dump = 0, n_rwe = 0;
   int wr0, cs0, d0, r0;

   logic [31:0] prog [$];
   logic [36:0] sb_w [$];
   logic [5:0]  sb_s [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [36:0] e;
      @(negedge clk1);
      if (imem_we === 1'b1) begin
         n_wr++;
         if (sb_w.size() == 0) begin
            chk("imem_extra", 1, 0);
         end else begin
            e = sb_w.pop_front();
            chk("imem_addr", 64'(imem_addr), 64'(e[36:32]));
            chk("imem_data", 64'(imem_wdata), 64'(e[31:0]));
         end
      end
      if (core_start === 1'b1) n_cs++;
      if (reg_raddr !== 5'd0) n_dump++;
      if (reg_we === 1'b1) n_rwe++;
      @(posedge clk1);
      #1;
   endtask

   task automatic launch(input bit has_last);
      int i;
      clr = 1'b1;
      step();
      clr = 1'b0;
      wr0 = n_wr; cs0 = n_cs; d0 = n_dump; r0 = n_rwe;
      go = 1'b1;
      step();
      go = 1'b0;
      i = 0;
      while (i < prog.size() && prog_ready) begin
         prog_valid = 1'b1;
         prog_data  = prog[i];
         prog_last  = has_last && (i == prog.size() - 1);
         sb_w.push_back({AW'(i), prog[i]});
         i++;
         step();
      end
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      prog_data  = '0;
   endtask

   task automatic finish_run(input string nm, input int exp_wr, input int exp_dump);
      int c;
      logic [5:0] e;
      c = 0;
      while (!done && c < 600) begin
         step();
         c++;
      end
      if (!done) begin
         chk({nm, "_done_to"}, 0, 1);
         sb_s.delete();
      end else begin
         e = sb_s.pop_front();
         chk({nm, "_done"}, 64'(done), 64'(e[5]));
         chk({nm, "_pass"}, 64'(pass), 64'(e[4]));
         chk({nm, "_tmo"}, 64'(timeout), 64'(e[3]));
         chk({nm, "_err"}, 64'(err_count), 64'(e[2:0]));
         chk({nm, "_busy"}, 64'(busy), 0);
      end
      chk({nm, "_cs"}, 64'(n_cs - cs0), 1);
      chk({nm, "_nwr"}, 64'(n_wr - wr0), 64'(exp_wr));
      chk({nm, "_dump"}, 64'(n_dump - d0), 64'(exp_dump));
      chk({nm, "_rwe"}, 64'(n_rwe - r0), 64'(N_RWE));
      chk({nm, "_sbw"}, 64'(sb_w.size()), 0);
   endtask

   task automatic set_good();
      prog.delete();
      prog.push_back(32'h2801000a); prog.push_back(32'h28020014);
      prog.push_back(32'h28030019); prog.push_back(32'h0ce77800);
      prog.push_back(32'h0ce77800); prog.push_back(32'h00222000);
      prog.push_back(32'h0ce77800); prog.push_back(32'h00832800);
      prog.push_back(32'hfc000000);
      exp_tbl[0] = 0;  exp_tbl[1] = 10; exp_tbl[2] = 20;
      exp_tbl[3] = 25; exp_tbl[4] = 30; exp_tbl[5] = 55;
   endtask

   function automatic logic all_outs_or();
      return |{prog_ready, imem_we, imem_addr, imem_wdata, reg_we, reg_waddr,
               reg_wdata, core_start, reg_raddr, busy, done, pass, timeout,
               err_count};
   endfunction

   initial begin
      int c;
      rst_n = 1'b0; go = 1'b0; prog_valid = 1'b0; prog_data = '0;
      prog_last = 1'b0; clr = 1'b1; stale_en = 1'b0;
      for (int i = 0; i < NR; i++) exp_tbl[i] = 0;
      repeat (3) step();
      chk("rst_outs", 64'(all_outs_or()), 0);
      chk("rst_busy", 64'(busy), 0);
      rst_n = 1'b1;
      clr = 1'b0;
      step();
      chk("idle_ready", 64'(prog_ready), 0);

      // good program
      set_good();
      sb_s.push_back({1'b1, 1'b1, 1'b0, 3'd0});
      launch(1'b1);
      finish_run("good", 9, NR - 1);

      // wrong expectation for R5
      set_good();
      exp_tbl[5] = 56;
      sb_s.push_back({1'b1, 1'b0, 1'b0, 3'd1});
      launch(1'b1);
      finish_run("mis", 9, NR - 1);

      // no HLT: watchdog
      set_good();
      prog[8] = 32'h0ce77800;
      sb_s.push_back({1'b1, 1'b0, 1'b1, 3'd0});
      launch(1'b1);
      finish_run("tmo", 9, 0);

      // 40 words, no prog_last: stops at the top of imem
      prog.delete();
      for (int i = 0; i < 40; i++) prog.push_back(32'h0ce77800 | 32'(i & 31));
      sb_s.push_back({1'b1, 1'b0, 1'b1, 3'd0});
      launch(1'b0);
      chk("full_ready", 64'(prog_ready), 0);
      finish_run("full", 32, 0);

      // reset mid-RUN, then a clean rerun
      set_good();
      launch(1'b1);
      c = 0;
      while (n_cs == cs0 && c < 200) begin
         step();
         c++;
      end
      chk("mid_started", 64'(n_cs - cs0), 1);
      step();
      step();
      chk("mid_busy", 64'(busy), 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_outs", 64'(all_outs_or()), 0);
      chk("mid_sbw", 64'(sb_w.size()), 0);
      sb_s.push_back({1'b1, 1'b1, 1'b0, 3'd0});
      launch(1'b1);
      finish_run("rerun", 9, NR - 1);

      // stale HALTED through START and first RUN cycle
      set_good();
      stale_en = 1'b1;
      sb_s.push_back({1'b1, 1'b1, 1'b0, 3'd0});
      launch(1'b1);
      finish_run("stale", 9, NR - 1);
      stale_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mips_test_sequencer.md
# mips_test_sequencer

Synthesizable self-checking harness for `pipe_MIPS32`. It replaces hand-written bench initialisation with one sequenced block. The sequence is: stream a program into instruction memory, optionally preload the register file, start the core, and wait for HALT under a watchdog. It then reads back the first NREG registers, compares them with expected values and reports pass/fail. It sits between an on-chip host/ROM stream and the core's memory/register back-door ports, so regressions run in simulation and on FPGA alike.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 5, instruction-memory address width (depth 2^ADDR_W)
- NREG, 6, registers checked after HALT (1..32)
- TIMEOUT, 255, max RUN cycles before abort (≥2)

- clk1  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- go  in  1  start request, sampled in IDLE/DONE only
- prog_valid  in  1  program word valid
- prog_ready  out  1  program word accepted when valid&ready
- prog_data  in  DATA_W  program word
- prog_last  in  1  marks final program word
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- reg_we  out  1  register-file preload strobe
- reg_waddr  out  5  preload address
- reg_wdata  out  DATA_W  preload data
- core_start  out  1  one-cycle pulse: core clears PC, HALTED, TAKEN_BRANCH
- core_halted  in  1  core HALTED flag
- reg_raddr  out  5  register read address; also expected-value index
- reg_rdata  in  DATA_W  register data, valid 1 cycle after reg_raddr
- exp_data  in  DATA_W  expected value for index reg_raddr, same cycle
- busy, done, pass, timeout  out  1  status
- err_count  out  $clog2(NREG+1)  mismatching registers

## Operation
- States: IDLE → LOAD → INIT → START → RUN → DUMP → DONE.
- IDLE/DONE: on go=1 → LOAD. Counters clear. done, pass, timeout and err_count clear. busy=1 in every state except IDLE and DONE.
- LOAD: prog_ready=1. Each handshake drives imem_we=1, imem_addr=wr_ptr and imem_wdata=prog_data in that same cycle, then wr_ptr increments. Exit to INIT after the handshake carrying prog_last=1, or after the handshake at wr_ptr=2^ADDR_W−1 (no wrap; later words are not accepted).
- INIT: drives reg_we=1, reg_waddr=k, reg_wdata=k for k=0..30 (31 cycles), then → START.
- START: core_start=1 for exactly one cycle, then → RUN.
- RUN: cycle counter starts at 0. core_halted is ignored in the first RUN cycle, because the core may still show a stale HALTED. From the second RUN cycle, core_halted=1 → DUMP. If the counter reaches TIMEOUT first → DONE with timeout=1 and pass=0. Simultaneous halt and timeout: halt wins.
- DUMP: reg_raddr steps 0..NREG−1, one index per cycle. exp_data is registered alongside. One cycle later reg_rdata is compared with the registered expected value, and err_count increments on mismatch, saturating at NREG. → DONE after the last compare. In DONE, pass = (err_count==0) & ~timeout.
- go outside IDLE/DONE is ignored. prog_valid outside LOAD is ignored.

## Timing
- Reset (rst_n=0 at an edge, any state, including mid-LOAD/RUN): state=IDLE. All outputs are 0 (prog_ready, imem_*, reg_*, core_start, reg_raddr, busy, done, pass, timeout, err_count).
- Latency, go to core_start: 1 + W + 31 + 1 cycles, where W is the number of LOAD cycles; without REGINIT this is 1 + W + 1.
- DUMP lasts NREG+1 cycles. done rises the cycle after the last compare.
- Memory write ports are combinational from state and counters. No output-side backpressure.

## Configuration
- MIPS_SEQ_REGINIT_EN defined: INIT state present, with register preload R[k]=k for k=0..30.
- Undefined: INIT removed, LOAD → START directly, and reg_we/reg_waddr/reg_wdata are tied to 0.

## Test plan
- Program 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (prog_last on 9th), expected R0..R5 = 0,10,20,25,30,55 → imem addresses 0..8 written, one core_start pulse, done=1, pass=1, err_count=0.
- Same program with exp_data for R5 = 56 → pass=0, err_count=1.
- Program without HLT (HLT word replaced by 0ce77800), TIMEOUT=40 → done=1, timeout=1, pass=0, DUMP never entered.
- 40 words with no prog_last, ADDR_W=5 → exactly 32 writes (addr 0..31), then prog_ready=0 and exit LOAD.
- rst_n=0 for one cycle mid-RUN → next cycle all outputs 0 and state IDLE; a new go reruns cleanly to pass=1.
- core_halted held at 1 through START and the first RUN cycle → no DUMP before the second RUN cycle. With MIPS_SEQ_REGINIT_EN undefined, reg_we stays 0 throughout.
